// File: rtl/display_scan_driver_pkg.sv
// Shared display definitions: default segment width, blank pattern and hex-to-7seg table.
package display_scan_driver_pkg;

    localparam int unsigned SEG_W_DEFAULT = 7;
    localparam logic [7:0]  SEG_BLANK     = 8'h00;

    // Segment order is {g,f,e,d,c,b,a}, active-high; used by upstream digit formatters.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_scan_driver_scan_prescaler.sv
// Slot prescaler: counts clk cycles within a digit slot, flags slot end and dead time.
module scan_prescaler #(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tc,        // slot ends on this edge
    output logic dead_next  // the count after this edge lies in the dead window
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_next;
    logic          frozen;  // en was low on the previous edge

    // Next count: hold while disabled, restart after a freeze, wrap at terminal count.
    always_comb begin
        tc        = 1'b0;
        pcnt_next = pcnt;
        if (en) begin
            if (frozen) begin
                pcnt_next = '0;
            end else if (pcnt == PW'(PRESCALE - 1)) begin
                pcnt_next = '0;
                tc        = 1'b1;
            end else begin
                pcnt_next = pcnt + 1'b1;
            end
        end
        dead_next = (32'(pcnt_next) < DEAD_CYCLES);
    end

    // Count and freeze-tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt   <= '0;
            frozen <= 1'b0;
        end else begin
            pcnt   <= pcnt_next;
            frozen <= !en;
        end
    end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with dead time and per-digit blanking.
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned SEG_W       = SEG_W_DEFAULT,
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned DEAD_CYCLES = 2,
    localparam int unsigned IDX_W      = $clog2(N_DIGITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_DIGITS-1:0]       blank_mask,
    input  logic [N_DIGITS*SEG_W-1:0] seg_in,
    output logic [N_DIGITS-1:0]       dig_n,
    output logic [SEG_W-1:0]          seg_out,
    output logic [IDX_W-1:0]          digit_idx,
    output logic                      frame_tick
);

    logic                tc;
    logic                dead_next;
    logic                last_digit;
    logic [IDX_W-1:0]    idx_next;
    logic [SEG_W-1:0]    seg_sel;
    logic [N_DIGITS-1:0] dig_n_next;

    scan_prescaler #(
        .PRESCALE    (PRESCALE),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .tc        (tc),
        .dead_next (dead_next)
    );

    // Slot index advance with explicit wrap so non-power-of-2 counts never overrun.
    always_comb begin
        last_digit = (digit_idx == IDX_W'(N_DIGITS - 1));
        idx_next   = digit_idx;
        if (tc) begin
            idx_next = last_digit ? '0 : digit_idx + 1'b1;
        end
    end

    // Pattern of the digit the next slot will show.
    always_comb begin
        seg_sel = '0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx_next == IDX_W'(i)) begin
                seg_sel = seg_in[i*SEG_W +: SEG_W];
            end
        end
    end

    // At most one enable low: only the next-slot digit, outside dead time, unmasked, enabled.
    always_comb begin
        dig_n_next = '1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (en && !dead_next && !blank_mask[i] && (idx_next == IDX_W'(i))) begin
                dig_n_next[i] = 1'b0;
            end
        end
    end

    // Output registers; seg_out is only reloaded when the slot changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_idx  <= '0;
            seg_out    <= SEG_W'(SEG_BLANK);
            dig_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            digit_idx  <= idx_next;
            dig_n      <= dig_n_next;
            frame_tick <= tc && last_digit;
            if (tc) begin
                seg_out <= seg_sel;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench: behavioural scan model on two configurations plus literal spot checks.
module tb_display_scan_driver;
    import display_scan_driver_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration A: 4 digits, 8-cycle slots. Configuration B: 6 digits, 4-cycle slots.
    logic        rst_a = 1'b1, en_a = 1'b1;
    logic [3:0]  mask_a = '0;
    logic [27:0] seg_a = '0;
    logic [3:0]  a_dig_n;
    logic [6:0]  a_seg;
    logic [1:0]  a_idx;
    logic        a_ft;

    logic        rst_b = 1'b1, en_b = 1'b1;
    logic [5:0]  mask_b = '0;
    logic [41:0] seg_b = '0;
    logic [5:0]  b_dig_n;
    logic [6:0]  b_seg;
    logic [2:0]  b_idx;
    logic        b_ft;

    display_scan_driver #(.N_DIGITS(4), .SEG_W(7), .PRESCALE(8), .DEAD_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .blank_mask(mask_a), .seg_in(seg_a),
        .dig_n(a_dig_n), .seg_out(a_seg), .digit_idx(a_idx), .frame_tick(a_ft)
    );

    display_scan_driver #(.N_DIGITS(6), .SEG_W(7), .PRESCALE(4), .DEAD_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .blank_mask(mask_b), .seg_in(seg_b),
        .dig_n(b_dig_n), .seg_out(b_seg), .digit_idx(b_idx), .frame_tick(b_ft)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int k = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a slot lasts pr enabled cycles; the first dd are dark; the slot digit is lit
    // unless masked; disabling darkens everything and the next enabled cycle restarts the slot.
    task automatic mstep(input int n, input int pr, input int dd, input logic r, input logic e,
                         input logic [7:0] mask, input logic [47:0] segs, input int sw,
                         input int idx_i, input int p_i, input bit run_i,
                         input logic [7:0] seg_i,
                         output int idx_o, output int p_o, output bit run_o,
                         output logic [7:0] seg_o, output logic [7:0] dig_o, output bit ft_o);
        logic [7:0] ones;
        ones = 8'((1 << n) - 1);
        idx_o = idx_i; p_o = p_i; seg_o = seg_i; ft_o = 1'b0; dig_o = ones;
        if (r) begin
            idx_o = 0; p_o = 0; run_o = 1'b1; seg_o = '0;
        end else if (!e) begin
            run_o = 1'b0;
        end else begin
            if (!run_i) begin
                p_o = 0;
            end else if (p_i == pr - 1) begin
                p_o   = 0;
                ft_o  = (idx_i == n - 1);
                idx_o = (idx_i + 1) % n;
                seg_o = 8'((segs >> (idx_o * sw)) & ((48'd1 << sw) - 1));
            end else begin
                p_o = p_i + 1;
            end
            run_o = 1'b1;
            if (p_o >= dd && !mask[idx_o]) dig_o[idx_o] = 1'b0;
        end
    endtask

    int ma_idx = 0, ma_p = 0, mb_idx = 0, mb_p = 0;
    bit ma_run = 1'b1, mb_run = 1'b1, ma_ft = 1'b0, mb_ft = 1'b0;
    logic [7:0] ma_seg = '0, ma_dig = '1, mb_seg = '0, mb_dig = '1;

    always @(posedge clk) begin
        mstep(4, 8, 2, rst_a, en_a, {4'b0, mask_a}, {20'b0, seg_a}, 7, ma_idx, ma_p, ma_run,
              ma_seg, ma_idx, ma_p, ma_run, ma_seg, ma_dig, ma_ft);
        mstep(6, 4, 2, rst_b, en_b, {2'b0, mask_b}, {6'b0, seg_b}, 7, mb_idx, mb_p, mb_run,
              mb_seg, mb_idx, mb_p, mb_run, mb_seg, mb_dig, mb_ft);
    end

    // Cycle-by-cycle comparison against the model, plus the one-hot-low invariant.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_dig_n", a_dig_n, ma_dig[3:0]);
            chk("a_seg_out", a_seg, ma_seg[6:0]);
            chk("a_digit_idx", a_idx, ma_idx);
            chk("a_frame_tick", a_ft, ma_ft);
            chk("a_one_low", $countones(~a_dig_n) <= 1, 1);
            chk("b_dig_n", b_dig_n, mb_dig[5:0]);
            chk("b_seg_out", b_seg, mb_seg[6:0]);
            chk("b_digit_idx", b_idx, mb_idx);
            chk("b_frame_tick", b_ft, mb_ft);
            chk("b_one_low", $countones(~b_dig_n) <= 1, 1);
        end
    end

    task automatic wait_k(input int t);
        while (k < t) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        seg_a = {hex_to_seg(4'h8), hex_to_seg(4'h4), hex_to_seg(4'h1), hex_to_seg(4'h0)};
        seg_b = {hex_to_seg(4'h5), hex_to_seg(4'h4), hex_to_seg(4'h3),
                 hex_to_seg(4'h2), hex_to_seg(4'h1), hex_to_seg(4'h0)};
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_a_dig", a_dig_n, 4'b1111);
        chk("rst_a_idx", a_idx, 0);
        chk("rst_a_seg", a_seg, 7'h00);
        chk("rst_a_ft", a_ft, 0);
        chk("rst_b_dig", b_dig_n, 6'b111111);
        rst_a = 1'b0;
        k = 0;

        // Scan order, dead time and frame tick.
        wait_k(1);  chk("t1_dead_k1", a_dig_n, 4'b1111);
        wait_k(2);  chk("t1_lit_k2", a_dig_n, 4'b1110);
        wait_k(7);  chk("t1_lit_k7", a_dig_n, 4'b1110);
        chk("t1_seg_k7", a_seg, 7'h00);
        wait_k(8);  chk("t1_dead_k8", a_dig_n, 4'b1111);
        chk("t1_idx_k8", a_idx, 1);
        chk("t3_seg_k8", a_seg, 7'h06);
        wait_k(10); chk("t1_lit_k10", a_dig_n, 4'b1101);
        wait_k(12); seg_a[13:7] = 7'h5B;
        wait_k(15); chk("t3_seg_hold", a_seg, 7'h06);
        wait_k(16); chk("t3_seg_slot2", a_seg, 7'h66);
        wait_k(18); chk("t1_lit_k18", a_dig_n, 4'b1011);
        wait_k(26); chk("t1_lit_k26", a_dig_n, 4'b0111);
        wait_k(31); chk("t1_ft_k31", a_ft, 0);
        wait_k(32); chk("t1_ft_k32", a_ft, 1);
        chk("t1_idx_k32", a_idx, 0);
        chk("t1_seg_k32", a_seg, 7'h3F);
        wait_k(33); chk("t1_ft_k33", a_ft, 0);
        wait_k(40); chk("t3_seg_new", a_seg, 7'h5B);
        mask_a = 4'b0100;

        // Blank mask: slot 2 stays dark but keeps its length; mid-slot blanking.
        wait_k(52); chk("t4_dark_slot2", a_dig_n, 4'b1111);
        chk("t4_idx_slot2", a_idx, 2);
        wait_k(56); chk("t4_idx_slot3", a_idx, 3);
        wait_k(58); chk("t4_lit_slot3", a_dig_n, 4'b0111);
        wait_k(67); chk("t4_lit_slot0", a_dig_n, 4'b1110);
        mask_a = 4'b0101;
        wait_k(68); chk("t4_blank_mid", a_dig_n, 4'b1111);
        wait_k(72); mask_a = 4'b0000;
        wait_k(74); chk("t4_unmask", a_dig_n, 4'b1101);

        // Freeze at pcnt=5 of slot 3, then restart with a full dead time.
        wait_k(93); chk("t5_pre", a_dig_n, 4'b0111);
        chk("t5_pre_idx", a_idx, 3);
        en_a = 1'b0;
        wait_k(94); chk("t5_off", a_dig_n, 4'b1111);
        chk("t5_off_idx", a_idx, 3);
        wait_k(96); en_a = 1'b1;
        wait_k(97); chk("t5_dead1", a_dig_n, 4'b1111);
        chk("t5_idx", a_idx, 3);
        wait_k(98); chk("t5_dead2", a_dig_n, 4'b1111);
        wait_k(99); chk("t5_relit", a_dig_n, 4'b0111);
        wait_k(105); chk("t5_wrap_idx", a_idx, 0);
        chk("t5_wrap_ft", a_ft, 1);

        // Six digits, 4-cycle slots, reset mid-slot 4.
        rst_b = 1'b0;
        k = 0;
        wait_k(2);  chk("t6_lit_k2", b_dig_n, 6'b111110);
        wait_k(4);  chk("t6_idx_k4", b_idx, 1);
        wait_k(20); chk("t6_idx_k20", b_idx, 5);
        wait_k(23); chk("t6_ft_k23", b_ft, 0);
        wait_k(24); chk("t6_idx_k24", b_idx, 0);
        chk("t6_ft_k24", b_ft, 1);
        wait_k(25); chk("t6_ft_k25", b_ft, 0);
        wait_k(40); chk("t6_idx_k40", b_idx, 4);
        wait_k(41); rst_b = 1'b1;
        wait_k(42); chk("t6_rst_idx", b_idx, 0);
        chk("t6_rst_dig", b_dig_n, 6'b111111);
        rst_b = 1'b0;

        // Random traffic on both configurations, checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_a = ($urandom_range(0, 499) == 0);
            rst_b = ($urandom_range(0, 499) == 0);
            en_a  = ($urandom_range(0, 9) != 0);
            en_b  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mask_a = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mask_b = 6'($urandom);
            if ($urandom_range(0, 3) == 0) seg_a = 28'($urandom);
            if ($urandom_range(0, 3) == 0) seg_b = {10'($urandom), 32'($urandom)};
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
